// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Full-adder cell: two half-adder stages whose carries are ORed.
// Purely combinational; one instance per serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/done valid-ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_co;

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  // Shift registers and carry hold still in DONE, freezing the result.
  assign sum_out     = sum_sh;
  assign cout        = carry;
  assign start_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      done_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
          carry  <= bit_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            done_valid <= 1'b1;
            state      <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB here
            ovf        <= carry ^ bit_co;
`endif
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          done_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors, decoupled monitor.
// Define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
    .sum_out     (sum_out),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed done handshake.
  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum_out", sum_out, e.s);
        check("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, e.o);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_ready_idle", start_ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo,
                        input int hold);
    int n;
    logic [W-1:0] s0;
    logic c0;
    wait_ready();
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    cin = c;
    done_ready = (hold == 0);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_in = ~a;
    b_in = W'($urandom);
    cin = ~c;
    sb.push_back('{s: es, c: ec, o: eo});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done_valid && n < W + 10);
    check("latency", n, W);
    if (hold > 0) begin
      s0 = sum_out;
      c0 = cout;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        start_valid = (i == 2);
        a_in = W'($urandom);
        check("hold_sum", sum_out, s0);
        check("hold_cout", cout, c0);
        check("hold_valid", done_valid, 1);
        check("hold_start_ready", start_ready, 0);
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      done_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("done_drop", done_valid, 0);
    check("ready_back", start_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout, 0);
    check("rst_valid", done_valid, 0);
    check("rst_busy", busy, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", start_ready, 1);

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 0);
    run_op(8'hC3, 8'h0F, 1'b0, 8'hD2, 1'b0, 1'b0, 5);

    // Abort mid-RUN; 0x33+0x44 has nonzero partial sum by then.
    wait_ready();
    start_valid = 1'b1;
    a_in = 8'h33;
    b_in = 8'h44;
    cin = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_sum", sum_out, 0);
    check("abort_cout", cout, 0);
    check("abort_valid", done_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", start_ready, 1);

    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with a carry flip-flop.
- The per-bit datapath is a full-adder cell built from two half-adder stages; this block is the sequential consumer of those half-adder outputs.
- Operands enter through a valid/ready start handshake. The result leaves through a valid/ready done handshake.
- Intended as the multi-cycle arithmetic stage in the adder exercise series.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operands a_in/b_in/cin are presented.
- start_ready  output  1  block can accept operands (high only in IDLE).
- a_in  input  WIDTH  operand A, captured on start handshake.
- b_in  input  WIDTH  operand B, captured on start handshake.
- cin  input  1  carry-in, captured on start handshake.
- sum_out  output  WIDTH  result; meaningful only while done_valid=1.
- cout  output  1  final carry-out; meaningful only while done_valid=1.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all shift registers, carry flop and bit counter cleared; sum_out=0, cout=0, done_valid=0, busy=0, start_ready=1 once reset is released.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready, capture a_in→a_sh, b_in→b_sh, cin→carry, clear counter, go to RUN.
  - RUN: start_ready=0. Each cycle the fa_cell adds a_sh[0], b_sh[0] and carry. The sum bit shifts into sum_sh MSB (sum_sh shifts right); a_sh and b_sh shift right; carry takes the cell carry-out; counter increments. When counter==WIDTH-1 on that edge, go to DONE.
  - DONE: done_valid=1. sum_out=sum_sh and cout=carry, held stable. On done_valid&&done_ready, go to IDLE and deassert done_valid.
- Latency: if the start handshake completes at edge N, done_valid=1 from edge N+WIDTH onward; exactly WIDTH RUN cycles.
- Throughput: at least one IDLE cycle between results; no overlap of start and done handshakes.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1); unsigned.
- Boundaries:
  - start_valid asserted in RUN/DONE: ignored, no capture.
  - Input changes after capture: no effect on the running addition.
  - done_ready held low: DONE held indefinitely with outputs frozen.
  - done_ready high before DONE: no effect.
  - Reset asserted mid-RUN or in DONE: immediate abort to the reset values; the result is lost.
- Counter width: $clog2(WIDTH)+1; no wrap inside a single operation.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
  - Registered during the final RUN bit.
  - Valid with done_valid; reset value 0; held in DONE.
- Undefined: no ovf port and no extra flop; the behaviour of all other ports is unchanged.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant.
- Sub-module fa_cell (combinational): two half-adder stages plus an OR; inputs x, y, ci; outputs s, co. Instantiated once in serial_adder.

Test Plan:
- Reset then 0x00+0x00, cin=0 → done_valid after 8 cycles; sum_out=0x00, cout=0.
- 0xFF+0x01, cin=0 → sum_out=0x00, cout=1; done_valid exactly 8 cycles after the accept edge.
- 0x5A+0x3C, cin=1 → sum_out=0x97, cout=0. Changing a_in/b_in during RUN does not alter the result.
- Backpressure: hold done_ready=0 for 5 cycles in DONE → sum_out, cout and done_valid stable; start_ready=0; a start_valid pulse is ignored. Release → IDLE next edge, start_ready=1.
- Reset mid-RUN: assert rst_n=0 after 3 RUN cycles → all outputs 0 asynchronously. Then a new 0x10+0x20 operation completes → 0x30, cout=0.
- With SERIAL_ADDER_OVF_EN defined:
  - 0x7F+0x01 → sum_out=0x80, cout=0, ovf=1.
  - 0x80+0x80 → sum_out=0x00, cout=1, ovf=1.
  - 0x01+0x02 → ovf=0.
